// File: rtl/instr_fetch_sequencer.sv
// Fetches a 32-bit instruction as four byte reads (A..A+3), assembled little-endian, returned over valid/ready.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned requests fault immediately without memory reads.
module instr_fetch_sequencer #(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned ADDRESS_WIDTH     = 32,
    parameter int unsigned INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         req_valid,
    input  logic [ADDRESS_WIDTH-1:0]     req_addr,
    output logic                         req_ready,
    output logic                         mem_en,
    output logic [ADDRESS_WIDTH-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    output logic                         rsp_valid,
    output logic [INSTRUCTION_WIDTH-1:0] rsp_instr,
    output logic                         rsp_fault,
    input  logic                         rsp_ready
);
    localparam int unsigned BEAT_W    = 2;
    localparam int unsigned NUM_BEATS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                         state_q, state_d;
    logic [BEAT_W-1:0]              beat_q, beat_d;
    logic [ADDRESS_WIDTH-1:0]       base_q, base_d;
    logic [INSTRUCTION_WIDTH-1:0]   asm_q, asm_d;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic                           fault_q, fault_d;
`endif

    // Next-state and datapath updates; flush discards everything in flight.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        asm_d   = asm_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_d = fault_q;
`endif
        if (flush) begin
            state_d = IDLE;
            beat_d  = '0;
            asm_d   = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        base_d  = req_addr;
                        beat_d  = '0;
                        asm_d   = '0;
                        state_d = READ;
`ifdef FETCH_MISALIGN_CHECK_EN
                        fault_d = 1'b0;
                        if (req_addr[1:0] != 2'b00) begin
                            state_d = RESP;
                            fault_d = 1'b1;
                        end
`endif
                    end
                end
                READ: begin
                    for (int unsigned i = 0; i < NUM_BEATS; i++) begin
                        if (beat_q == BEAT_W'(i)) begin
                            asm_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
                        end
                    end
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(NUM_BEATS - 1)) begin
                        state_d = RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_d = IDLE;
`ifdef FETCH_MISALIGN_CHECK_EN
                        fault_d = 1'b0;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            asm_q   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            asm_q   <= asm_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

    // Outputs decode flops only; no path from req_* or rsp_ready.
    assign req_ready = (state_q == IDLE);
    assign mem_en    = (state_q == READ);
    assign mem_addr  = base_q + ADDRESS_WIDTH'(beat_q);
    assign rsp_valid = (state_q == RESP);
    assign rsp_instr = asm_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign rsp_fault = fault_q;
`else
    assign rsp_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer against a 16-byte ROM image aliased by mem_addr[3:0].
`timescale 1ns/1ps
module tb_instr_fetch_sequencer;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic        rsp_fault;
    logic        rsp_ready;

    logic [7:0]  rom [16];
    int          n_tests;
    int          n_fail;
    int          cyc;
    int          last_rsp_cyc;
    int          first_rsp_cyc;

    instr_fetch_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_instr (rsp_instr),
        .rsp_fault (rsp_fault),
        .rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = rom[mem_addr[3:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the handshake, back in IDLE.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] w, input int hold);
        logic mis;
        mis = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        mis = (a[1:0] != 2'b00);
`endif
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEEF;
        if (!mis) begin
            for (int b = 0; b < 4; b++) begin
                check("read_mem_en", 32'(mem_en), 32'd1);
                check("read_mem_addr", mem_addr, a + 32'(b));
                check("read_req_ready", 32'(req_ready), 32'd0);
                check("read_rsp_valid", 32'(rsp_valid), 32'd0);
                @(negedge clk);
            end
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_instr", rsp_instr, mis ? 32'd0 : w);
        check("rsp_fault", 32'(rsp_fault), 32'(mis));
        last_rsp_cyc = cyc;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_instr", rsp_instr, mis ? 32'd0 : w);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_mem_en", 32'(mem_en), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_hs_req_ready", 32'(req_ready), 32'd1);
        check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_hs_mem_en", 32'(mem_en), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        last_rsp_cyc  = 0;
        first_rsp_cyc = 0;
        rom[0]  = 8'h93; rom[1]  = 8'h02; rom[2]  = 8'h10; rom[3]  = 8'h00;
        rom[4]  = 8'h13; rom[5]  = 8'h03; rom[6]  = 8'h20; rom[7]  = 8'h00;
        rom[8]  = 8'hB3; rom[9]  = 8'h83; rom[10] = 8'h62; rom[11] = 8'h00;
        rom[12] = 8'h37; rom[13] = 8'h05; rom[14] = 8'h00; rom[15] = 8'h5A;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_instr", rsp_instr, 32'h0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_fetch(32'hBFC0_0000, 32'h0010_0293, 0);
        do_fetch(32'hBFC0_0000, 32'h0010_0293, 3);

        // Back-to-back: responses exactly 6 cycles apart
        do_fetch(32'hBFC0_0000, 32'h0010_0293, 0);
        first_rsp_cyc = last_rsp_cyc;
        do_fetch(32'hBFC0_0004, 32'h0020_0313, 0);
        check("b2b_spacing", 32'(last_rsp_cyc - first_rsp_cyc), 32'd6);

        // Flush during beat 2
        req_valid = 1'b1; req_addr = 32'hBFC0_0004;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("flush_beat2_addr", mem_addr, 32'hBFC0_0006);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_mem_en", 32'(mem_en), 32'd0);
        check("flush_req_ready", 32'(req_ready), 32'd1);
        repeat (4) begin
            check("flush_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        do_fetch(32'hBFC0_0008, 32'h0062_83B3, 0);

        // Flush beats a request in the same IDLE cycle
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'hBFC0_0000;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        check("flush_pri_req_ready", 32'(req_ready), 32'd1);
        check("flush_pri_mem_en", 32'(mem_en), 32'd0);

        // Reset during beat 1, with flush also high
        req_valid = 1'b1; req_addr = 32'hBFC0_000C;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_beat1_addr", mem_addr, 32'hBFC0_000D);
        rst = 1'b1; flush = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        check("midrst_mem_en", 32'(mem_en), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rsp_instr", rsp_instr, 32'h0);
        check("midrst_mem_addr", mem_addr, 32'h0);

        // Address wrap at the top of the address space: bytes 15,0,1,2
        do_fetch(32'hFFFF_FFFF, 32'h1002_935A, 1);
        // Misaligned: faults with the macro, else reads bytes 2..5
        do_fetch(32'hBFC0_0002, 32'h0313_0010, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_sequencer.md
# instr_fetch_sequencer

Sequencing controller between the fetch stage and a byte-wide (8-bit) instruction memory port. It accepts one fetch address per request, issues four consecutive byte reads (A, A+1, A+2, A+3) and assembles them little-endian into a 32-bit instruction. It returns the instruction over a valid/ready handshake. It sits between the PC/fetch logic and the boot ROM window 0xBFC00000–0xBFC00FFF, and allows the ROM to be built with a single byte read port.

## Interface

Parameters:
- DATA_WIDTH, 8: memory byte width.
- ADDRESS_WIDTH, 32: byte address width.
- INSTRUCTION_WIDTH, 32: assembled word width. Must equal 4*DATA_WIDTH.

Ports:
- clk  input  1  Single clock. All state updates on the rising edge.
- rst  input  1  Reset. Synchronous and active-high.
- flush  input  1  Synchronous abort of any in-flight fetch.
- req_valid  input  1  Fetch request present.
- req_addr  input  ADDRESS_WIDTH  Byte address of the instruction.
- req_ready  output  1  Block can accept a request.
- mem_en  output  1  Byte read active this cycle.
- mem_addr  output  ADDRESS_WIDTH  Byte address to the memory.
- mem_rdata  input  DATA_WIDTH  Byte read data, combinational from mem_addr.
- rsp_valid  output  1  Assembled instruction available.
- rsp_instr  output  INSTRUCTION_WIDTH  Assembled instruction.
- rsp_fault  output  1  Misaligned-address fault. Driven only with the configuration macro; otherwise constant 0.
- rsp_ready  input  1  Consumer accepts the response.

## Operation

- States: IDLE, READ, RESP.
- IDLE:
  - req_ready=1, mem_en=0, rsp_valid=0.
  - On req_valid&&req_ready: latch req_addr into base, clear the beat counter and the assembly register, and go to READ.
- READ:
  - mem_en=1, mem_addr=base+beat.
  - beat is a 2-bit counter. The addition is ADDRESS_WIDTH bits, modulo 2^ADDRESS_WIDTH, so 0xFFFFFFFF+1 wraps to 0x00000000.
  - Each edge stores mem_rdata into assembly byte lane [beat] (beat 0 is bits 7:0, beat 3 is bits 31:24), then increments beat.
  - After the beat-3 capture, go to RESP.
- RESP:
  - rsp_valid=1, rsp_instr=assembly register. Both are held stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready, go to IDLE.
- req_ready is 0 in READ and RESP. Requests presented then are not accepted and must be held by the requester.
- flush:
  - In any state, forces IDLE next edge and discards the partial or complete word. No response is produced.
  - flush has priority over a request handshake in the same IDLE cycle: the request is not accepted.
  - flush has priority over rsp_ready in RESP.
- rst has priority over flush.
- Reset values: state=IDLE, beat=0, assembly register=0, base=0, req_ready=1 (from IDLE), mem_en=0, mem_addr=0, rsp_valid=0, rsp_instr=0, rsp_fault=0.

## Timing

- Request accepted at edge E0. Bytes are captured at edges E1–E4. rsp_valid rises after E4: 5 cycles from the request cycle to response, minimum.
- Back-to-back throughput: 1 instruction per 6 cycles (accept, 4 reads, response handshake). req_ready returns 1 in the cycle after the response handshake.
- mem_addr and mem_en are registered-state-derived only. They have no combinational path from req_* or rsp_ready.
- rsp_instr is unchanged between the cycle rsp_valid rises and the handshake.
- Reset asserted mid-READ: the next edge yields IDLE with all outputs at reset values. No memory read is issued in the following cycle.

## Configuration

- Macro FETCH_MISALIGN_CHECK_EN.
- Defined:
  - An accepted request with req_addr[1:0]!=0 skips READ and goes directly to RESP next edge.
  - In that response, rsp_fault=1 and rsp_instr=0, and mem_en stays 0.
  - Aligned requests behave as without the macro, with rsp_fault=0.
- Undefined:
  - rsp_fault is constant 0.
  - Any address, aligned or not, performs the four byte reads.

## Test plan

- Reset then single fetch: ROM bytes at 0xBFC00000..3 = 93,02,10,00, req_addr=0xBFC00000 -> mem_addr steps 0xBFC00000..0xBFC00003 over 4 cycles, then rsp_valid=1 with rsp_instr=0x00100293.
- Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid -> rsp_instr stable, req_ready=0, mem_en=0; handshake then req_ready=1 next cycle.
- Back-to-back fetches at 0xBFC00000 and 0xBFC00004 with rsp_ready=1 -> two responses 6 cycles apart, second word from bytes 4..7.
- flush asserted during beat 2 -> IDLE next edge, no rsp_valid; a new request at 0xBFC00008 then completes normally.
- Reset asserted during beat 1 -> next cycle mem_en=0, rsp_valid=0, req_ready=1, rsp_instr=0.
- With FETCH_MISALIGN_CHECK_EN, req_addr=0xBFC00002 -> no mem_en, rsp_valid=1 after 1 edge, rsp_fault=1, rsp_instr=0. Without the macro -> 4 reads from 0xBFC00002, rsp_fault=0.
